// File: rtl/fifo4_wr_rd_ctrl_pkg.sv
// Shared sizing constants for the 4-entry FIFO controller that drives an
// external 4x4 register file.
package fifo4_wr_rd_ctrl_pkg;
   localparam int unsigned DATA_W = 4;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned PTR_W  = 2;
   localparam int unsigned CNT_W  = 3;
endpackage

// File: rtl/fifo4_wr_rd_ctrl_if.sv
// FIFO user handshake plus register-file side signals of the controller.
interface fifo4_wr_rd_ctrl_if #(
   parameter int unsigned DATA_W = fifo4_wr_rd_ctrl_pkg::DATA_W
);
   import fifo4_wr_rd_ctrl_pkg::*;

   logic                push;
   logic [DATA_W-1:0]   push_data;
   logic                pop;
   logic [DATA_W-1:0]   pop_data;
   logic                pop_valid;
   logic                full;
   logic                empty;
   logic [CNT_W-1:0]    count;
   logic                overflow;
   logic                underflow;
   logic [DATA_W-1:0]   rf_data_in;
   logic                rf_wr_enb;
   logic [PTR_W-1:0]    rf_wr_sel;
   logic                rf_rd_enb;
   logic [PTR_W-1:0]    rf_rd_sel;
   logic [DATA_W-1:0]   rf_data_out;

   modport master (
      output push, push_data, pop, rf_data_out,
      input  pop_data, pop_valid, full, empty, count, overflow, underflow,
             rf_data_in, rf_wr_enb, rf_wr_sel, rf_rd_enb, rf_rd_sel
   );

   modport slave (
      input  push, push_data, pop, rf_data_out,
      output pop_data, pop_valid, full, empty, count, overflow, underflow,
             rf_data_in, rf_wr_enb, rf_wr_sel, rf_rd_enb, rf_rd_sel
   );
endinterface

// File: rtl/fifo4_wr_rd_ctrl.sv
// Write/read controller for a 4-deep FIFO; storage lives in an external 4x4
// register file with active-low strobes and a transparent write port.
module fifo4_wr_rd_ctrl #(
   parameter int unsigned DATA_W = fifo4_wr_rd_ctrl_pkg::DATA_W,
   parameter int unsigned DEPTH  = fifo4_wr_rd_ctrl_pkg::DEPTH
) (
   input  logic               clk,
   input  logic               rst,
   fifo4_wr_rd_ctrl_if.slave  bus
);
   import fifo4_wr_rd_ctrl_pkg::*;

   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_full;
   logic              r_empty;
   logic [DATA_W-1:0] r_rf_data_in;
   logic              r_rf_wr_enb;
   logic [PTR_W-1:0]  r_rf_wr_sel;
   logic              r_rf_rd_enb;
   logic [DATA_W-1:0] r_pop_data;
   logic              r_pop_valid;
   logic              r_overflow;
   logic              r_underflow;

   logic              w_push_ok;
   logic              w_pop_ok;
   logic [CNT_W-1:0]  w_cnt_nxt;

   // Acceptance uses only registered flags, so no push/pop -> flag path exists.
   always_comb begin
      w_push_ok = bus.push & ~r_full;
      w_pop_ok  = bus.pop & ~r_empty;
      w_cnt_nxt = r_count;
      case ({w_push_ok, w_pop_ok})
         2'b10:   w_cnt_nxt = r_count + CNT_W'(1);
         2'b01:   w_cnt_nxt = r_count - CNT_W'(1);
         default: w_cnt_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_full       <= 1'b0;
         r_empty      <= 1'b1;
         r_rf_data_in <= '0;
         r_rf_wr_enb  <= 1'b1;
         r_rf_wr_sel  <= '0;
         r_rf_rd_enb  <= 1'b1;
         r_pop_data   <= '0;
         r_pop_valid  <= 1'b0;
         r_overflow   <= 1'b0;
         r_underflow  <= 1'b0;
      end else begin
         // Write strobe fires in the cycle after acceptance with address/data held.
         r_rf_wr_enb <= ~w_push_ok;
         if (w_push_ok) begin
            r_rf_data_in <= bus.push_data;
            r_rf_wr_sel  <= r_wr_ptr;
            r_wr_ptr     <= r_wr_ptr + PTR_W'(1);
         end
         r_pop_valid <= w_pop_ok;
         if (w_pop_ok) begin
            r_pop_data <= bus.rf_data_out;
            r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
         end
         r_count     <= w_cnt_nxt;
         r_full      <= (w_cnt_nxt == CNT_W'(DEPTH));
         r_empty     <= (w_cnt_nxt == '0);
         r_rf_rd_enb <= (w_cnt_nxt == '0);
         if (bus.push & r_full)
            r_overflow <= 1'b1;
         if (bus.pop & r_empty)
            r_underflow <= 1'b1;
      end
   end

   assign bus.rf_data_in = r_rf_data_in;
   assign bus.rf_wr_enb  = r_rf_wr_enb;
   assign bus.rf_wr_sel  = r_rf_wr_sel;
   assign bus.rf_rd_enb  = r_rf_rd_enb;
   assign bus.rf_rd_sel  = r_rd_ptr;
   assign bus.pop_data   = r_pop_data;
   assign bus.pop_valid  = r_pop_valid;
   assign bus.full       = r_full;
   assign bus.empty      = r_empty;
   assign bus.count      = r_count;
   assign bus.overflow   = r_overflow;
   assign bus.underflow  = r_underflow;

endmodule

// File: tb/tb_fifo4_wr_rd_ctrl.sv
// Directed bench for fifo4_wr_rd_ctrl with a behavioural 4x4 register file
// (transparent write, active-low strobes).
module tb_fifo4_wr_rd_ctrl;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   fifo4_wr_rd_ctrl_if #(.DATA_W(4)) bus ();

   fifo4_wr_rd_ctrl #(.DATA_W(4), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register-file model: write on the edge ending a low-strobe cycle, bypass same-address reads.
   logic [3:0] mem [4];
   always_ff @(posedge clk)
      if (!bus.rf_wr_enb) mem[bus.rf_wr_sel] <= bus.rf_data_in;
   assign bus.rf_data_out = bus.rf_rd_enb ? 4'h0 :
                            (!bus.rf_wr_enb && bus.rf_wr_sel == bus.rf_rd_sel) ? bus.rf_data_in :
                            mem[bus.rf_rd_sel];

   typedef struct {
      logic       rst;
      logic       push;
      logic [3:0] din;
      logic       pop;
      logic [2:0] cnt;
      logic       full;
      logic       empty;
      logic       wen;
      logic [1:0] wsel;
      logic [3:0] wdin;
      logic       pv;
      logic [3:0] pd;
      logic       ovf;
      logic       unf;
      logic [1:0] rsel;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic pu, logic [3:0] d, logic po,
                               logic [2:0] c, logic f, logic e, logic we, logic [1:0] ws,
                               logic [3:0] wd, logic pv, logic [3:0] pd, logic ov,
                               logic un, logic [1:0] rs);
      vec_t v;
      v.rst = r;  v.push = pu; v.din = d;   v.pop = po;
      v.cnt = c;  v.full = f;  v.empty = e; v.wen = we; v.wsel = ws; v.wdin = wd;
      v.pv = pv;  v.pd = pd;   v.ovf = ov;  v.unf = un; v.rsel = rs;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [7:0] act,
                      input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step%0d got=%0h want=%0h", name, idx, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic pu, input logic [3:0] d, input logic po);
      rst = r; bus.push = pu; bus.push_data = d; bus.pop = po;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1; bus.push = 1'b0; bus.push_data = '0; bus.pop = 1'b0;

      //            rst pu din   po  cnt f  e  wen ws wdin pv pd   ov un rs
      vecs.push_back(mk(1, 0, 4'h0, 0, 0, 0, 1, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 4'hA, 0, 1, 0, 0, 0, 0, 4'hA, 0, 4'h0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 4'h5, 0, 2, 0, 0, 0, 1, 4'h5, 0, 4'h0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 4'h3, 0, 3, 0, 0, 0, 2, 4'h3, 0, 4'h0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 4'hC, 0, 4, 1, 0, 0, 3, 4'hC, 0, 4'h0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 4'hF, 0, 4, 1, 0, 1, 3, 4'h0, 0, 4'h0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 4'h0, 1, 3, 0, 0, 1, 3, 4'h0, 1, 4'hA, 1, 0, 1));
      vecs.push_back(mk(0, 0, 4'h0, 1, 2, 0, 0, 1, 3, 4'h0, 1, 4'h5, 1, 0, 2));
      vecs.push_back(mk(0, 0, 4'h0, 1, 1, 0, 0, 1, 3, 4'h0, 1, 4'h3, 1, 0, 3));
      vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 1, 1, 3, 4'h0, 1, 4'hC, 1, 0, 0));
      vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 1, 1, 3, 4'h0, 0, 4'h0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 1, 1, 3, 4'h0, 0, 4'h0, 1, 1, 0));
      vecs.push_back(mk(0, 1, 4'h1, 0, 1, 0, 0, 0, 0, 4'h1, 0, 4'h0, 1, 1, 0));
      vecs.push_back(mk(0, 1, 4'h2, 0, 2, 0, 0, 0, 1, 4'h2, 0, 4'h0, 1, 1, 0));
      vecs.push_back(mk(0, 1, 4'h7, 1, 2, 0, 0, 0, 2, 4'h7, 1, 4'h1, 1, 1, 1));
      vecs.push_back(mk(0, 0, 4'h0, 1, 1, 0, 0, 1, 2, 4'h0, 1, 4'h2, 1, 1, 2));
      vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 1, 1, 2, 4'h0, 1, 4'h7, 1, 1, 3));
      vecs.push_back(mk(0, 1, 4'h9, 0, 1, 0, 0, 0, 3, 4'h9, 0, 4'h0, 1, 1, 3));
      vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 1, 1, 3, 4'h0, 1, 4'h9, 1, 1, 0));
      vecs.push_back(mk(0, 1, 4'h4, 1, 1, 0, 0, 0, 0, 4'h4, 0, 4'h0, 1, 1, 0));
      vecs.push_back(mk(0, 1, 4'h6, 0, 2, 0, 0, 0, 1, 4'h6, 0, 4'h0, 1, 1, 0));
      vecs.push_back(mk(0, 1, 4'h8, 0, 3, 0, 0, 0, 2, 4'h8, 0, 4'h0, 1, 1, 0));
      vecs.push_back(mk(0, 1, 4'hB, 0, 4, 1, 0, 0, 3, 4'hB, 0, 4'h0, 1, 1, 0));
      vecs.push_back(mk(0, 1, 4'hD, 1, 3, 0, 0, 1, 3, 4'h0, 1, 4'h4, 1, 1, 1));
      vecs.push_back(mk(0, 0, 4'h0, 1, 2, 0, 0, 1, 3, 4'h0, 1, 4'h6, 1, 1, 2));
      vecs.push_back(mk(0, 1, 4'hE, 0, 3, 0, 0, 0, 0, 4'hE, 0, 4'h0, 1, 1, 2));
      vecs.push_back(mk(1, 1, 4'h5, 1, 0, 0, 1, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 1, 1, 0, 4'h0, 0, 4'h0, 0, 1, 0));
      vecs.push_back(mk(0, 1, 4'h2, 0, 1, 0, 0, 0, 0, 4'h2, 0, 4'h0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 1, 1, 0, 4'h0, 1, 4'h2, 0, 1, 1));

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].push, vecs[i].din, vecs[i].pop);
         chk("count",     i, 8'(bus.count),     8'(vecs[i].cnt));
         chk("full",      i, 8'(bus.full),      8'(vecs[i].full));
         chk("empty",     i, 8'(bus.empty),     8'(vecs[i].empty));
         chk("rf_rd_enb", i, 8'(bus.rf_rd_enb), 8'(vecs[i].empty));
         chk("rf_rd_sel", i, 8'(bus.rf_rd_sel), 8'(vecs[i].rsel));
         chk("rf_wr_enb", i, 8'(bus.rf_wr_enb), 8'(vecs[i].wen));
         chk("rf_wr_sel", i, 8'(bus.rf_wr_sel), 8'(vecs[i].wsel));
         chk("pop_valid", i, 8'(bus.pop_valid), 8'(vecs[i].pv));
         chk("overflow",  i, 8'(bus.overflow),  8'(vecs[i].ovf));
         chk("underflow", i, 8'(bus.underflow), 8'(vecs[i].unf));
         if (vecs[i].rst || !vecs[i].wen)
            chk("rf_data_in", i, 8'(bus.rf_data_in), 8'(vecs[i].wdin));
         if (vecs[i].rst || vecs[i].pv)
            chk("pop_data", i, 8'(bus.pop_data), 8'(vecs[i].pd));
      end

      // Wrap: ten push/pop pairs from reset, write address must cycle 0..3.
      step(1'b1, 1'b0, 4'h0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, 4'(i), 1'b0);
         chk("wrap_wr_enb", i, 8'(bus.rf_wr_enb), 8'd0);
         chk("wrap_wr_sel", i, 8'(bus.rf_wr_sel), 8'(i % 4));
         chk("wrap_count",  i, 8'(bus.count),     8'd1);
         step(1'b0, 1'b0, 4'h0, 1'b1);
         chk("wrap_pv",     i, 8'(bus.pop_valid), 8'd1);
         chk("wrap_pd",     i, 8'(bus.pop_data),  8'(i));
         chk("wrap_empty",  i, 8'(bus.empty),     8'd1);
      end
      step(1'b0, 1'b0, 4'h0, 1'b0);
      chk("wrap_pv_end", 0, 8'(bus.pop_valid), 8'd0);
      chk("wrap_flags",  0, 8'({bus.overflow, bus.underflow}), 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo4_wr_rd_ctrl.md
FIFO4_WR_RD_CTRL -- requirements
Module: fifo4_wr_rd_ctrl

Interface
REQ-001 Parameter DATA_W, default 4, SHALL set the data width to match the 4x4 register file.
REQ-002 Parameter DEPTH, default 4, SHALL be fixed at 4; the pointers SHALL be 2 bits wide.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 push  in  1  request to write push_data.
REQ-007 push_data  in  DATA_W  write data.
REQ-008 pop  in  1  request to read the oldest entry.
REQ-009 rf_data_in  out  DATA_W  registered data to the register-file data_in.
REQ-010 rf_wr_enb  out  1  register-file write strobe, active-low.
REQ-011 rf_wr_sel  out  2  register-file write address.
REQ-012 rf_rd_enb  out  1  register-file read enable, active-low.
REQ-013 rf_rd_sel  out  2  register-file read address.
REQ-014 rf_data_out  in  DATA_W  register-file read data.
REQ-015 pop_data  out  DATA_W  registered popped data.
REQ-016 pop_valid  out  1  one-cycle pulse qualifying pop_data.
REQ-017 full, empty  out  1 each  occupancy flags.
REQ-018 count  out  3  occupancy, 0..4.
REQ-019 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-020 Accept push: push & ~full, with full sampled at the start of the cycle.
REQ-021 Accept pop: pop & ~empty, with empty sampled at the start of the cycle.
REQ-022 Accepted push, cycle t:
- rf_data_in <= push_data and rf_wr_sel <= wr_ptr at the edge ending t.
- rf_wr_enb SHALL be low for exactly cycle t+1, otherwise high.
- wr_ptr SHALL increment modulo 4.
REQ-023 rf_wr_sel and rf_data_in SHALL hold stable throughout the cycle in which rf_wr_enb is low; no combinational path from push to rf_wr_enb.
REQ-024 rf_rd_sel SHALL equal rd_ptr at all times.
REQ-025 rf_rd_enb SHALL be low whenever empty is low, and high when empty.
REQ-026 Accepted pop, cycle t:
- pop_data <= rf_data_out at the edge ending t.
- pop_valid high for cycle t+1 only.
- rd_ptr SHALL increment modulo 4.
REQ-027 Write latency: data pushed in cycle t SHALL be poppable from cycle t+1 (the transparent write in t+1 makes it visible at rf_data_out).
REQ-028 count SHALL be updated each cycle:
- +1 on an accepted push only.
- -1 on an accepted pop only.
- unchanged when both are accepted or neither is.
REQ-029 full = (count==4); empty = (count==0); both registered-derived, with no dependency on push or pop in the same cycle.
REQ-030 Simultaneous push & pop when full: the pop SHALL be accepted, the push rejected, and count goes to 3.
REQ-031 Simultaneous push & pop when empty: the push SHALL be accepted, the pop rejected, and count goes to 1.
REQ-032 Simultaneous push & pop with 0<count<4: both SHALL be accepted; count unchanged; both pointers advance.
REQ-033 Rejected push SHALL set overflow; rejected pop SHALL set underflow; both hold until reset.
REQ-034 Pointer wrap 3->0 SHALL occur without any bubble or flag glitch.

Reset
REQ-035 On rst high at a clock edge:
- wr_ptr, rd_ptr and count SHALL be 0.
- empty=1, full=0.
- rf_wr_enb=1, rf_rd_enb=1.
- pop_valid=0, overflow=0, underflow=0.
- pop_data, rf_data_in and rf_wr_sel SHALL be 0.
REQ-036 Reset mid-operation SHALL abort any pending write strobe (rf_wr_enb high in the next cycle) and discard all stored entries logically; register-file contents are not cleared.
REQ-037 push and pop SHALL be ignored in any cycle with rst high.

Structure
REQ-038 A shared package SHALL hold DATA_W, DEPTH, PTR_W=2 and CNT_W=3.
REQ-039 The block SHALL contain no storage array; storage is the external 4x4 register file.
REQ-040 The top-level test wrapper SHALL instantiate fifo4_wr_rd_ctrl with the existing 4x4 register-file module; no other sub-module.

Verification
REQ-041 Push 4'hA,4'h5,4'h3,4'hC, then pop 4 times -> pop_data A,5,3,C, each with a one-cycle pop_valid; after the 4th push full=1, count=4; at the end empty=1.
REQ-042 Full, push 4'hF -> rejected, overflow=1, count stays 4; the following pops return the original 4 entries.
REQ-043 Empty, pop -> no pop_valid, underflow=1, rf_rd_enb stays high.
REQ-044 count=2, simultaneous push 4'h7 & pop -> count stays 2, the oldest entry is popped, and 4'h7 is returned after the remaining entry.
REQ-045 Wrap test: 10 push/pop pairs of values 0..9 -> in-order output, and rf_wr_sel sequence 0,1,2,3,0,1,...
REQ-046 Assert rst while count=3 with a write strobe pending -> next cycle count=0, empty=1, rf_wr_enb=1, flags cleared.
